set_assoc_cache: RTL and testbench
==================================

// Module: set_assoc_cache
// PURPOSE
//  Parametrised N-way set-associative, write-back, write-allocate data cache (one word per line)
//  between the CPU data port and main data memory. Hits are served locally. Misses stall the CPU
//  (Ready low) while an FSM writes back the dirty victim and then allocates the line over a
//  req/ack handshake. Victim choice is true LRU.
// PARAMETERS
//  DATA_WIDTH      32   word/address width; multiple of 8
//  SET_ADDR_WIDTH  2    set index bits; 2**SET_ADDR_WIDTH sets
//  WAYS            2    associativity; power of 2, >=2
//  TAG_WIDTH       DATA_WIDTH-SET_ADDR_WIDTH-2 (derived)
//  NBYTES          DATA_WIDTH/8 (derived)
// PORTS
//  CLK       in   1           clock, rising edge
//  RST       in   1           async active-high reset
//  Req       in   1           CPU access request; held with A/WD/ByteEn/MemWrite until Ready
//  MemWrite  in   1           1=store, 0=load
//  ByteEn    in   NBYTES      store byte enables
//  A         in   DATA_WIDTH  byte address; set=A[SET_ADDR_WIDTH+1:2], tag=A[DW-1:SET_ADDR_WIDTH+2]
//  WD        in   DATA_WIDTH  store data
//  RD        out  DATA_WIDTH  load data, valid while Ready=1
//  Ready     out  1           one-cycle pulse: access complete
//  MReq      out  1           memory request, held until MAck
//  MWE       out  1           1=writeback, 0=line fill
//  MA        out  DATA_WIDTH  word-aligned memory address
//  MWD       out  DATA_WIDTH  writeback data
//  MRD       in   DATA_WIDTH  fill data, valid with MAck
//  MAck      in   1           memory done; ignored while MReq=0
// BEHAVIOUR
//  Reset (async): FSM=IDLE; all V/D cleared; way w age=w; Ready,MReq,MWE=0; RD,MA,MWD=0.
//   Reset mid-transaction drops MReq at once; the pending access is lost.
//  Per-line state: {V,D,tag,data}. Per-set state: age[WAYS] (log2 WAYS bits each); 0=MRU.
//  FSM:
//   IDLE: Req=1 -> latch A/WD/ByteEn/MemWrite -> LOOKUP. Req is sampled only in IDLE.
//   LOOKUP: hit = V & tag match in any way (at most one).
//    Hit load: RD=data, Ready=1.
//    Hit store: merge enabled bytes, D=1, Ready=1.
//    On any hit: LRU touch -> IDLE.
//    Miss: victim = lowest-index invalid way, else way with age=WAYS-1.
//     Victim V&D -> WRITEBACK; otherwise -> ALLOCATE.
//   WRITEBACK: MReq=1, MWE=1, MA={victim tag,set,2'b00}, MWD=victim data, all stable.
//    MAck -> ALLOCATE.
//   ALLOCATE: MReq=1, MWE=0, MA={latched tag,set,2'b00}.
//    MAck -> victim={V=1,D=0,tag,MRD} -> LOOKUP (re-lookup hits).
//  Latency: hit = Ready 1 cycle after Req sampled. Miss = +1 cycle per state + memory wait.
//  LRU touch (way h): ages < age[h] increment; age[h]=0. Ages remain a permutation of 0..WAYS-1.
//  Ready is low in every non-LOOKUP state.
//  Back-to-back: Req held high after Ready starts a new access next cycle (IDLE).
//  MReq drops the cycle after MAck. A MAck coincident with MReq rise is valid (0-wait memory).
//  Store miss: fill first, then merge on re-lookup. Fill data does not bypass to RD.
// TESTING (DATA_WIDTH=32, SET_ADDR_WIDTH=2, WAYS=2; set stride 0x10)
//  1 Reset; load A=0x100 -> MReq,MWE=0,MA=0x100; MAck,MRD=0xDEADBEEF -> Ready,RD=0xDEADBEEF;
//    reload 0x100 -> Ready 1 cycle after Req, no MReq.
//  2 Store 0x100 ByteEn=0011 WD=0x12345678 (hit) -> no MReq;
//    load 0x100 -> RD=0xDEAD5678.
//  3 Fill 0x000,0x010; store 0x000; load 0x010; load 0x020
//    -> WRITEBACK MA=0x000 MWD=stored word, then ALLOCATE MA=0x020.
//  4 Clean lines 0x000,0x010, access order 0x000,0x010,0x000; load 0x020
//    -> no writeback, 0x010 evicted; then 0x000 hits.
//  5 MAck delayed 5 cycles -> MReq/MWE/MA/MWD stable throughout, Ready=0 until completion.
//  6 RST asserted in ALLOCATE -> MReq=0 same cycle; after release load 0x100 misses again.

Source files
------------

// File: rtl/set_assoc_cache_if.sv
// set_assoc_cache_if
//  Bundles the CPU data port and the main-memory port of the cache.
//  slave  : view used by the cache (receives CPU requests, issues memory requests)
//  master : view used by the CPU/memory side that drives the cache
//  CPU side   : Req, MemWrite, ByteEn, A, WD -> cache; RD, Ready <- cache
//  Memory side: MReq, MWE, MA, MWD <- cache; MRD, MAck -> cache
interface set_assoc_cache_if #(
  parameter int DATA_WIDTH = 32
) ();
  localparam int NBYTES = DATA_WIDTH / 8;

  logic                  Req;
  logic                  MemWrite;
  logic [NBYTES-1:0]     ByteEn;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] WD;
  logic [DATA_WIDTH-1:0] RD;
  logic                  Ready;

  logic                  MReq;
  logic                  MWE;
  logic [DATA_WIDTH-1:0] MA;
  logic [DATA_WIDTH-1:0] MWD;
  logic [DATA_WIDTH-1:0] MRD;
  logic                  MAck;

  modport slave (
    input  Req, MemWrite, ByteEn, A, WD, MRD, MAck,
    output RD, Ready, MReq, MWE, MA, MWD
  );

  modport master (
    output Req, MemWrite, ByteEn, A, WD, MRD, MAck,
    input  RD, Ready, MReq, MWE, MA, MWD
  );
endinterface

// File: rtl/set_assoc_cache.sv
// set_assoc_cache
//  N-way set-associative, write-back, write-allocate data cache, one word per
//  line, true-LRU replacement. Hits complete in the cycle after the request is
//  sampled; misses write back a dirty victim, fill the line from memory and
//  then re-run the lookup, which is guaranteed to hit.
// Ports
//  CLK : rising-edge clock
//  RST : asynchronous active-high reset
//  bus : set_assoc_cache_if.slave (CPU request/response + memory req/ack)
module set_assoc_cache #(
  parameter int DATA_WIDTH     = 32,
  parameter int SET_ADDR_WIDTH = 2,
  parameter int WAYS           = 2
) (
  input logic              CLK,
  input logic              RST,
  set_assoc_cache_if.slave bus
);
  localparam int TAG_WIDTH = DATA_WIDTH - SET_ADDR_WIDTH - 2;
  localparam int NBYTES    = DATA_WIDTH / 8;
  localparam int NSETS     = 2 ** SET_ADDR_WIDTH;
  localparam int AGE_W     = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, ALLOCATE} state_t;

  state_t state, state_next;

  logic                  valid    [NSETS][WAYS];
  logic                  dirty    [NSETS][WAYS];
  logic [TAG_WIDTH-1:0]  tag_mem  [NSETS][WAYS];
  logic [DATA_WIDTH-1:0] data_mem [NSETS][WAYS];
  logic [AGE_W-1:0]      age      [NSETS][WAYS];

  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [NBYTES-1:0]     be_q;
  logic                  we_q;
  logic [AGE_W-1:0]      victim_q;

  logic [SET_ADDR_WIDTH-1:0] set_idx;
  logic [TAG_WIDTH-1:0]      tag_in;
  logic                      unused_byte_offset;

  assign set_idx            = a_q[SET_ADDR_WIDTH+1:2];
  assign tag_in             = a_q[DATA_WIDTH-1:SET_ADDR_WIDTH+2];
  assign unused_byte_offset = ^a_q[1:0];

  logic                  hit;
  logic [AGE_W-1:0]      hit_way;
  logic [AGE_W-1:0]      victim_way;
  logic [DATA_WIDTH-1:0] hit_data;
  logic [DATA_WIDTH-1:0] merged;

  // Victim: the LRU way, overridden by the lowest-index invalid way. The
  // descending loop lets the lowest invalid index win.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    victim_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[set_idx][w] && (tag_mem[set_idx][w] == tag_in)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (age[set_idx][w] == AGE_W'(WAYS - 1)) begin
        victim_way = AGE_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[set_idx][w]) begin
        victim_way = AGE_W'(w);
      end
    end
    hit_data = data_mem[set_idx][hit_way];
    merged   = hit_data;
    for (int b = 0; b < NBYTES; b++) begin
      if (be_q[b]) begin
        merged[8*b +: 8] = wd_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    bus.Ready  = 1'b0;
    bus.RD     = '0;
    bus.MReq   = 1'b0;
    bus.MWE    = 1'b0;
    bus.MA     = '0;
    bus.MWD    = '0;
    case (state)
      IDLE: begin
        if (bus.Req) begin
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          bus.Ready  = 1'b1;
          bus.RD     = hit_data;
          state_next = IDLE;
        end else if (valid[set_idx][victim_way] && dirty[set_idx][victim_way]) begin
          state_next = WRITEBACK;
        end else begin
          state_next = ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.MReq = 1'b1;
        bus.MWE  = 1'b1;
        bus.MA   = {tag_mem[set_idx][victim_q], set_idx, 2'b00};
        bus.MWD  = data_mem[set_idx][victim_q];
        if (bus.MAck) begin
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        bus.MReq = 1'b1;
        bus.MA   = {tag_in, set_idx, 2'b00};
        if (bus.MAck) begin
          state_next = LOOKUP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // LRU touch on hit: ways younger than the hit way age by one, hit way
  // becomes MRU, so ages stay a permutation of 0..WAYS-1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q      <= '0;
      wd_q     <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      victim_q <= '0;
      for (int s = 0; s < NSETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid[s][w] <= 1'b0;
          dirty[s][w] <= 1'b0;
          age[s][w]   <= AGE_W'(w);
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.Req) begin
            a_q  <= bus.A;
            wd_q <= bus.WD;
            be_q <= bus.ByteEn;
            we_q <= bus.MemWrite;
          end
        end
        LOOKUP: begin
          if (hit) begin
            for (int w = 0; w < WAYS; w++) begin
              if (AGE_W'(w) == hit_way) begin
                age[set_idx][w] <= '0;
              end else if (age[set_idx][w] < age[set_idx][hit_way]) begin
                age[set_idx][w] <= age[set_idx][w] + 1'b1;
              end
            end
            if (we_q) begin
              dirty[set_idx][hit_way] <= 1'b1;
            end
          end else begin
            victim_q <= victim_way;
          end
        end
        ALLOCATE: begin
          if (bus.MAck) begin
            valid[set_idx][victim_q] <= 1'b1;
            dirty[set_idx][victim_q] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits gate their use.
  always_ff @(posedge CLK) begin
    if ((state == LOOKUP) && hit && we_q) begin
      data_mem[set_idx][hit_way] <= merged;
    end
    if ((state == ALLOCATE) && bus.MAck) begin
      tag_mem[set_idx][victim_q]  <= tag_in;
      data_mem[set_idx][victim_q] <= bus.MRD;
    end
  end
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache
//  Self-checking bench for set_assoc_cache (DATA_WIDTH=32, 4 sets, 2 ways).
//  A recency-stamp cache model predicts memory transactions, load data and
//  access latency; a memory responder plays main memory and checks every
//  memory-request cycle against the predicted transactions.
`timescale 1ns/1ps
module tb_set_assoc_cache;
  localparam int DW    = 32;
  localparam int WAYS  = 2;
  localparam int NSETS = 4;
  localparam int TW    = 28;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          delay;
  } txn_t;

  logic CLK = 1'b0;
  logic RST;

  set_assoc_cache_if #(.DATA_WIDTH(DW)) bus ();

  set_assoc_cache #(
    .DATA_WIDTH(DW),
    .SET_ADDR_WIDTH(2),
    .WAYS(WAYS)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;
  logic cpu_busy = 1'b0;

  txn_t exp_q[$];
  logic [31:0] model_mem [bit [31:0]];
  logic [31:0] phys_mem  [bit [31:0]];

  logic          mvalid [NSETS][WAYS];
  logic          mdirty [NSETS][WAYS];
  logic [TW-1:0] mtag   [NSETS][WAYS];
  logic [31:0]   mdata  [NSETS][WAYS];
  int            mstamp [NSETS][WAYS];
  int            tick = 0;

  int          txn_count = 0;
  logic [31:0] last_wb_addr = '0;
  logic [31:0] last_wb_data = '0;
  logic [31:0] last_fill_addr = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic int pickDelay(input int dly);
    return (dly >= 0) ? dly : int'($urandom_range(0, 3));
  endfunction

  function automatic void resetModel();
    for (int s = 0; s < NSETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        mvalid[s][w] = 1'b0;
        mdirty[s][w] = 1'b0;
        mstamp[s][w] = 0;
      end
    end
    exp_q.delete();
  endfunction

  // Model: resident lines per set with last-use stamps; the oldest stamp is LRU.
  task automatic predict(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input int dly,
                         output logic [31:0] rd_exp, output int lat_exp);
    int s, w_hit, w_v, ntx, sumd, d;
    logic [31:0] wa, va, line;
    s     = int'(addr[3:2]);
    wa    = {addr[31:2], 2'b00};
    tick++;
    w_hit = -1;
    ntx   = 0;
    sumd  = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (mvalid[s][w] && (mtag[s][w] == addr[31:4])) w_hit = w;
    end
    if (w_hit < 0) begin
      w_v = -1;
      for (int w = 0; w < WAYS; w++) begin
        if (!mvalid[s][w] && (w_v < 0)) w_v = w;
      end
      if (w_v < 0) begin
        w_v = 0;
        for (int w = 1; w < WAYS; w++) begin
          if (mstamp[s][w] < mstamp[s][w_v]) w_v = w;
        end
        if (mdirty[s][w_v]) begin
          va = {mtag[s][w_v], addr[3:2], 2'b00};
          d  = pickDelay(dly);
          exp_q.push_back('{we: 1'b1, addr: va, data: mdata[s][w_v], delay: d});
          model_mem[va] = mdata[s][w_v];
          ntx++;
          sumd += d;
        end
      end
      d = pickDelay(dly);
      exp_q.push_back('{we: 1'b0, addr: wa, data: 32'h0, delay: d});
      ntx++;
      sumd += d;
      if (!model_mem.exists(wa)) model_mem[wa] = initWord(wa);
      mvalid[s][w_v] = 1'b1;
      mdirty[s][w_v] = 1'b0;
      mtag[s][w_v]   = addr[31:4];
      mdata[s][w_v]  = model_mem[wa];
      w_hit = w_v;
    end
    if (we) begin
      line = mdata[s][w_hit];
      for (int b = 0; b < 4; b++) begin
        if (be[b]) line[8*b +: 8] = wd[8*b +: 8];
      end
      mdata[s][w_hit]  = line;
      mdirty[s][w_hit] = 1'b1;
    end
    mstamp[s][w_hit] = tick;
    rd_exp  = mdata[s][w_hit];
    lat_exp = (ntx == 0) ? 1 : (ntx + sumd + 2);
  endtask

  task automatic doReset();
    @(negedge CLK);
    RST      = 1'b1;
    bus.Req  = 1'b0;
    cpu_busy = 1'b0;
    resetModel();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                               input logic [31:0] wd, input int dly,
                               output logic [31:0] rd_act, output int lat_act);
    logic [31:0] rd_exp;
    int lat_exp;
    bit done;
    predict(addr, we, be, wd, dly, rd_exp, lat_exp);
    @(negedge CLK);
    cpu_busy     = 1'b1;
    bus.Req      = 1'b1;
    bus.A        = addr;
    bus.MemWrite = we;
    bus.ByteEn   = be;
    bus.WD       = wd;
    lat_act = 0;
    rd_act  = '0;
    done    = 1'b0;
    while (!done && (lat_act < 200)) begin
      @(negedge CLK);
      lat_act++;
      if (bus.Ready) begin
        done    = 1'b1;
        rd_act  = bus.RD;
        bus.Req = 1'b0;
      end
    end
    if (!done) begin
      checkOutput("ready_timeout", 32'(lat_act), 32'(lat_exp));
      doReset();
    end else begin
      checkOutput("latency", 32'(lat_act), 32'(lat_exp));
      if (!we) checkOutput("RD", rd_act, rd_exp);
      checkOutput("pending_txns", 32'(exp_q.size()), 32'd0);
      @(posedge CLK);
      cpu_busy = 1'b0;
    end
  endtask

  // Memory responder and per-cycle checker.
  initial begin
    txn_t cur;
    bit in_txn;
    int wait_left;
    in_txn    = 1'b0;
    wait_left = 0;
    cur       = '{we: 1'b0, addr: 32'hFFFF_FFFF, data: 32'h0, delay: 0};
    bus.MAck  = 1'b0;
    bus.MRD   = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        in_txn   = 1'b0;
        bus.MAck = 1'b0;
      end else begin
        if (!cpu_busy) checkOutput("idle_ready", 32'(bus.Ready), 32'd0);
        if (bus.MReq) begin
          checkOutput("ready_during_mreq", 32'(bus.Ready), 32'd0);
          if (!in_txn) begin
            txn_count++;
            checkOutput("mreq_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else cur = '{we: 1'b0, addr: 32'hFFFF_FFFF, data: 32'h0, delay: 0};
            in_txn    = 1'b1;
            wait_left = cur.delay;
            if (bus.MWE) begin
              last_wb_addr = bus.MA;
              last_wb_data = bus.MWD;
            end else begin
              last_fill_addr = bus.MA;
            end
          end
          checkOutput("MWE", 32'(bus.MWE), 32'(cur.we));
          checkOutput("MA", bus.MA, cur.addr);
          if (cur.we) checkOutput("MWD", bus.MWD, cur.data);
          if (wait_left == 0) begin
            bus.MAck = 1'b1;
            if (bus.MWE) begin
              phys_mem[bus.MA] = bus.MWD;
              bus.MRD = $urandom;
            end else begin
              if (!phys_mem.exists(bus.MA)) phys_mem[bus.MA] = initWord(bus.MA);
              bus.MRD = phys_mem[bus.MA];
            end
            in_txn = 1'b0;
          end else begin
            bus.MAck = 1'b0;
            bus.MRD  = $urandom;
            wait_left--;
          end
        end else begin
          if (in_txn) begin
            checkOutput("mreq_held", 32'(bus.MReq), 32'd1);
            in_txn = 1'b0;
          end
          bus.MAck = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat;
    int tx0;
    bit seen;
    logic [31:0] unused_rd;
    int unused_lat;

    RST          = 1'b1;
    bus.Req      = 1'b0;
    bus.MemWrite = 1'b0;
    bus.ByteEn   = '0;
    bus.A        = '0;
    bus.WD       = '0;
    phys_mem[32'h100]  = 32'hDEADBEEF;
    model_mem[32'h100] = 32'hDEADBEEF;
    resetModel();
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("rst_Ready", 32'(bus.Ready), 32'd0);
    checkOutput("rst_MReq", 32'(bus.MReq), 32'd0);
    checkOutput("rst_MWE", 32'(bus.MWE), 32'd0);
    checkOutput("rst_RD", bus.RD, 32'd0);
    checkOutput("rst_MA", bus.MA, 32'd0);
    checkOutput("rst_MWD", bus.MWD, 32'd0);
    RST = 1'b0;

    $display("[TB] load miss/hit at 0x100");
    tx0 = txn_count;
    applyStimulus(32'h100, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    checkOutput("t1_fill_lat", 32'(lat), 32'd3);
    checkOutput("t1_fill_rd", rd, 32'hDEADBEEF);
    checkOutput("t1_fill_ma", last_fill_addr, 32'h100);
    applyStimulus(32'h100, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    checkOutput("t1_hit_lat", 32'(lat), 32'd1);
    checkOutput("t1_hit_rd", rd, 32'hDEADBEEF);

    $display("[TB] store hit byte merge");
    applyStimulus(32'h100, 1'b1, 4'b0011, 32'h12345678, 0, rd, lat);
    checkOutput("t2_store_lat", 32'(lat), 32'd1);
    applyStimulus(32'h100, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    checkOutput("t2_merge_rd", rd, 32'hDEAD5678);
    checkOutput("t2_no_mreq", 32'(txn_count - tx0), 32'd1);

    $display("[TB] dirty eviction");
    doReset();
    applyStimulus(32'h000, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    applyStimulus(32'h010, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    applyStimulus(32'h000, 1'b1, 4'hF, 32'hCAFEF00D, 0, rd, lat);
    applyStimulus(32'h010, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    applyStimulus(32'h020, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    checkOutput("t3_evict_lat", 32'(lat), 32'd4);
    checkOutput("t3_wb_ma", last_wb_addr, 32'h000);
    checkOutput("t3_wb_mwd", last_wb_data, 32'hCAFEF00D);
    checkOutput("t3_fill_ma", last_fill_addr, 32'h020);

    $display("[TB] clean LRU eviction");
    doReset();
    applyStimulus(32'h000, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    applyStimulus(32'h010, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    applyStimulus(32'h000, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    applyStimulus(32'h010, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    applyStimulus(32'h000, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    tx0 = txn_count;
    applyStimulus(32'h020, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    checkOutput("t4_clean_lat", 32'(lat), 32'd3);
    checkOutput("t4_one_txn", 32'(txn_count - tx0), 32'd1);
    applyStimulus(32'h000, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    checkOutput("t4_mru_kept", 32'(lat), 32'd1);
    applyStimulus(32'h010, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    checkOutput("t4_lru_gone", 32'(lat), 32'd3);

    $display("[TB] slow memory");
    doReset();
    applyStimulus(32'h040, 1'b0, 4'h0, 32'h0, 5, rd, lat);
    checkOutput("t5_slow_fill_lat", 32'(lat), 32'd8);
    applyStimulus(32'h050, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    applyStimulus(32'h040, 1'b1, 4'hF, 32'h0BAD_CAFE, 0, rd, lat);
    applyStimulus(32'h050, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    applyStimulus(32'h060, 1'b0, 4'h0, 32'h0, 5, rd, lat);
    checkOutput("t5_slow_evict_lat", 32'(lat), 32'd14);
    checkOutput("t5_wb_mwd", last_wb_data, 32'h0BAD_CAFE);

    $display("[TB] reset during allocate");
    doReset();
    predict(32'h100, 1'b0, 4'h0, 32'h0, 20, unused_rd, unused_lat);
    @(negedge CLK);
    cpu_busy     = 1'b1;
    bus.Req      = 1'b1;
    bus.A        = 32'h100;
    bus.MemWrite = 1'b0;
    bus.ByteEn   = 4'h0;
    seen = 1'b0;
    for (int i = 0; (i < 10) && !seen; i++) begin
      @(negedge CLK);
      if (bus.MReq) seen = 1'b1;
    end
    checkOutput("t6_alloc_reached", 32'(seen), 32'd1);
    @(posedge CLK);
    #1;
    checkOutput("t6_mreq_before", 32'(bus.MReq), 32'd1);
    RST = 1'b1;
    #1;
    checkOutput("t6_mreq_drop", 32'(bus.MReq), 32'd0);
    checkOutput("t6_ready_low", 32'(bus.Ready), 32'd0);
    bus.Req  = 1'b0;
    cpu_busy = 1'b0;
    resetModel();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    applyStimulus(32'h100, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    checkOutput("t6_miss_again_lat", 32'(lat), 32'd3);
    checkOutput("t6_refill_ma", last_fill_addr, 32'h100);

    $display("[TB] randomized accesses");
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = {(($urandom_range(0, 3) == 0) ? 24'hF0F0F0 : 24'h000000), 6'($urandom_range(0, 31)), 2'b00};
      applyStimulus(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, -1, rd, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
